// File: rtl/load_exec_unit_if.sv
// Load-unit bus bundle: issue port from the load RS, data-memory read port, and CDB broadcast port.
interface load_exec_unit_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_rob;
  logic [31:0] issue_base;
  logic [31:0] issue_offset;
  logic [2:0]  issue_subtype;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        cdb_req;
  logic        cdb_gnt;
  logic [5:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic        cdb_exc;

  modport slave (
    input  issue_valid, issue_rob, issue_base, issue_offset, issue_subtype, flush,
    input  mem_gnt, mem_rvalid, mem_rdata, cdb_gnt,
    output issue_ready, mem_req, mem_addr, cdb_req, cdb_rob, cdb_data, cdb_exc
  );

  modport master (
    output issue_valid, issue_rob, issue_base, issue_offset, issue_subtype, flush,
    output mem_gnt, mem_rvalid, mem_rdata, cdb_gnt,
    input  issue_ready, mem_req, mem_addr, cdb_req, cdb_rob, cdb_data, cdb_exc
  );
endinterface

// File: rtl/load_exec_unit.sv
// Single-entry load execution unit: address generation, alignment check, one memory read,
// byte/half extraction and a CDB broadcast, with squash handling for in-flight loads.
module load_exec_unit (
  input  logic           clock,
  input  logic           reset,
  load_exec_unit_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_BCAST = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [5:0]  rob_q, rob_d;
  logic [2:0]  sub_q, sub_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] data_q, data_d;
  logic        exc_q, exc_d;

  logic [31:0] ea_new;
  logic        bad_new;
  logic        handshake;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  assign ea_new = bus.issue_base + bus.issue_offset;

  always_comb begin
    case (bus.issue_subtype)
      3'b000, 3'b100: bad_new = 1'b0;
      3'b001, 3'b101: bad_new = ea_new[0];
      3'b010:         bad_new = |ea_new[1:0];
      default:        bad_new = 1'b1;
    endcase
  end

  always_comb begin
    case (ea_q[1:0])
      2'd0:    byte_lane = bus.mem_rdata[7:0];
      2'd1:    byte_lane = bus.mem_rdata[15:8];
      2'd2:    byte_lane = bus.mem_rdata[23:16];
      default: byte_lane = bus.mem_rdata[31:24];
    endcase
    half_lane = ea_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (sub_q)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_val = {24'd0, byte_lane};
      3'b101:  load_val = {16'd0, half_lane};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Gated by reset so nothing is accepted while the unit is being cleared.
  assign bus.issue_ready = (state_q == S_IDLE) && !bus.flush && !reset;
  assign handshake       = bus.issue_valid && bus.issue_ready;

  always_comb begin
    state_d = state_q;
    rob_d   = rob_q;
    sub_d   = sub_q;
    ea_d    = ea_q;
    data_d  = data_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: if (handshake) begin
        rob_d   = bus.issue_rob;
        sub_d   = bus.issue_subtype;
        ea_d    = ea_new;
        data_d  = 32'd0;
        exc_d   = bad_new;
        state_d = bad_new ? S_BCAST : S_REQ;
      end
      S_REQ: begin
        if (bus.mem_gnt)    state_d = bus.flush ? S_DRAIN : S_WAIT;
        else if (bus.flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (bus.flush) state_d = bus.mem_rvalid ? S_IDLE : S_DRAIN;
        else if (bus.mem_rvalid) begin
          data_d  = load_val;
          state_d = S_BCAST;
        end
      end
      S_BCAST: if (bus.flush || bus.cdb_gnt) state_d = S_IDLE;
      S_DRAIN: if (bus.mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rob_q   <= 6'd0;
      sub_q   <= 3'd0;
      ea_q    <= 32'd0;
      data_q  <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rob_q   <= rob_d;
      sub_q   <= sub_d;
      ea_q    <= ea_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.mem_req  = (state_q == S_REQ);
  assign bus.mem_addr = bus.mem_req ? {ea_q[31:2], 2'b00} : 32'd0;
  assign bus.cdb_req  = (state_q == S_BCAST);
  assign bus.cdb_rob  = bus.cdb_req ? rob_q  : 6'd0;
  assign bus.cdb_data = bus.cdb_req ? data_q : 32'd0;
  assign bus.cdb_exc  = bus.cdb_req && exc_q;
endmodule

// File: tb/tb_load_exec_unit.sv
// Directed bench for load_exec_unit with a transaction-level expectation model and a per-cycle compare.
module tb_load_exec_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  load_exec_unit_if bus();
  load_exec_unit dut (.clock(clock), .reset(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int nbc = 0;
  int exp_bc = 0;

  logic        exp_mem_ok = 1'b0;
  logic        exp_cdb_ok = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [5:0]  exp_rob = '0;
  logic        exp_exc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(input logic [2:0] st, input logic [31:0] ea);
    case (st)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (ea % 2) == 0;
      3'b010:         return (ea % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] st, input logic [31:0] ea, input logic [31:0] w);
    int unsigned bsh, hsh;
    logic [31:0] t;
    bsh = 8 * (ea % 4);
    hsh = 16 * ((ea / 2) % 2);
    case (st)
      3'b000: begin t = w << (24 - bsh); return $signed(t) >>> 24; end
      3'b001: begin t = w << (16 - hsh); return $signed(t) >>> 16; end
      3'b100: return (w >> bsh) & 32'h0000_00FF;
      3'b101: return (w >> hsh) & 32'h0000_FFFF;
      3'b010: return w;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle compare of the output ports against the model's expectation.
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_cdb_req", {31'd0, bus.cdb_req}, 32'd0);
    end else begin
      if (bus.mem_req) begin
        chk("mem_req_expected", {31'd0, exp_mem_ok}, 32'd1);
        chk("mem_addr", bus.mem_addr, exp_addr);
      end else chk("mem_addr_idle", bus.mem_addr, 32'd0);
      if (bus.cdb_req) begin
        chk("cdb_req_expected", {31'd0, exp_cdb_ok}, 32'd1);
        chk("cdb_rob", {26'd0, bus.cdb_rob}, {26'd0, exp_rob});
        chk("cdb_data", bus.cdb_data, exp_data);
        chk("cdb_exc", {31'd0, bus.cdb_exc}, {31'd0, exp_exc});
      end else begin
        chk("cdb_rob_idle", {26'd0, bus.cdb_rob}, 32'd0);
        chk("cdb_data_idle", bus.cdb_data, 32'd0);
        chk("cdb_exc_idle", {31'd0, bus.cdb_exc}, 32'd0);
      end
    end
  end

  always @(posedge clock)
    if (!reset && bus.cdb_req && bus.cdb_gnt && !bus.flush) nbc++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [5:0] rob, input logic [31:0] base, input logic [31:0] off,
                       input logic [2:0] st);
    bus.issue_valid = 1'b1;
    bus.issue_rob = rob;
    bus.issue_base = base;
    bus.issue_offset = off;
    bus.issue_subtype = st;
  endtask

  // Accept one load at the next edge and arm the model for its memory phase or exception broadcast.
  task automatic hs(input logic [5:0] rob, input logic [31:0] base, input logic [31:0] off,
                    input logic [2:0] st);
    logic [31:0] ea;
    ea = base + off;
    issue(rob, base, off, st);
    @(negedge clock) chk("issue_ready_pre", {31'd0, bus.issue_ready}, 32'd1);
    step();
    bus.issue_valid = 1'b0;
    exp_rob = rob;
    if (m_legal(st, ea)) begin
      exp_addr = ea & 32'hFFFF_FFFC;
      exp_mem_ok = 1'b1;
    end else begin
      exp_data = 32'd0;
      exp_exc = 1'b1;
      exp_cdb_ok = 1'b1;
    end
  endtask

  task automatic do_load(input logic [5:0] rob, input logic [31:0] base, input logic [31:0] off,
                         input logic [2:0] st, input int gd, input int rd, input int cd,
                         input logic [31:0] rdata);
    logic [31:0] ea;
    ea = base + off;
    hs(rob, base, off, st);
    if (m_legal(st, ea)) begin
      for (int i = 0; i < gd; i++) begin
        @(negedge clock) chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
        chk("ready_busy", {31'd0, bus.issue_ready}, 32'd0);
        step();
      end
      bus.mem_gnt = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      @(negedge clock) chk("mem_req_gnt", {31'd0, bus.mem_req}, 32'd1);
      step();
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      exp_mem_ok = 1'b0;
      for (int i = 0; i < rd; i++) begin
        @(negedge clock) chk("no_cdb_in_wait", {31'd0, bus.cdb_req}, 32'd0);
        step();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = rdata;
      @(negedge clock) chk("no_cdb_at_rvalid", {31'd0, bus.cdb_req}, 32'd0);
      step();
      bus.mem_rvalid = 1'b0;
      exp_data = m_ext(st, ea, rdata);
      exp_exc = 1'b0;
      exp_cdb_ok = 1'b1;
    end
    for (int i = 0; i < cd; i++) begin
      @(negedge clock) chk("cdb_req_hold", {31'd0, bus.cdb_req}, 32'd1);
      chk("ready_bcast", {31'd0, bus.issue_ready}, 32'd0);
      step();
    end
    bus.cdb_gnt = 1'b1;
    @(negedge clock) chk("cdb_req_gnt", {31'd0, bus.cdb_req}, 32'd1);
    step();
    bus.cdb_gnt = 1'b0;
    exp_cdb_ok = 1'b0;
    exp_bc++;
    @(negedge clock) chk("cdb_req_done", {31'd0, bus.cdb_req}, 32'd0);
    chk("ready_after", {31'd0, bus.issue_ready}, 32'd1);
    step();
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_rob = '0; bus.issue_base = '0; bus.issue_offset = '0;
    bus.issue_subtype = '0; bus.flush = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0; bus.cdb_gnt = 1'b0;

    // Model pins from hand-worked examples.
    chk("pin_lb", m_ext(3'b000, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    chk("pin_lhu", m_ext(3'b101, 32'h1FE, 32'hBEEF_1234), 32'h0000_BEEF);
    chk("pin_lh", m_ext(3'b001, 32'h2, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_lw_mis", {31'd0, m_legal(3'b010, 32'h102)}, 32'd0);

    #2;
    chk("rst_mem_req0", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_cdb_req0", {31'd0, bus.cdb_req}, 32'd0);
    chk("rst_mem_addr0", bus.mem_addr, 32'd0);
    chk("rst_cdb_data0", bus.cdb_data, 32'd0);
    step(); step();
    reset = 1'b0;
    @(negedge clock) chk("ready_out_of_reset", {31'd0, bus.issue_ready}, 32'd1);
    step();

    do_load(6'd1, 32'h100, 32'd3, 3'b000, 0, 0, 0, 32'h80FF_0000);
    do_load(6'd2, 32'h200, 32'hFFFF_FFFE, 3'b101, 1, 1, 1, 32'hBEEF_1234);
    do_load(6'd3, 32'h100, 32'd2, 3'b010, 0, 0, 0, 32'h0);
    do_load(6'd4, 32'h40, 32'd0, 3'b010, 3, 0, 2, 32'hCAFE_F00D);
    do_load(6'd5, 32'h0, 32'd2, 3'b001, 0, 2, 0, 32'h8001_0000);
    do_load(6'd6, 32'h11, 32'd0, 3'b101, 0, 0, 1, 32'h0);
    do_load(6'd7, 32'h1, 32'd0, 3'b000, 0, 0, 0, 32'h0000_7F00);
    do_load(6'd8, 32'h2, 32'd0, 3'b100, 0, 0, 0, 32'h00AB_0000);
    do_load(6'd9, 32'h20, 32'd0, 3'b101, 0, 0, 0, 32'h1234_FFFF);
    do_load(6'd10, 32'h20, 32'd0, 3'b011, 0, 0, 0, 32'h0);
    do_load(6'd11, 32'h20, 32'd0, 3'b110, 0, 0, 0, 32'h0);
    do_load(6'd12, 32'h20, 32'd0, 3'b111, 0, 0, 0, 32'h0);

    // Flush in WAIT, rvalid two cycles later, next load waiting with issue_valid high.
    hs(6'd20, 32'h300, 32'd0, 3'b010);
    bus.mem_gnt = 1'b1;
    @(negedge clock); step();
    bus.mem_gnt = 1'b0; exp_mem_ok = 1'b0;
    bus.flush = 1'b1;
    @(negedge clock) chk("ready_flush_wait", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.flush = 1'b0;
    issue(6'd21, 32'h401, 32'd0, 3'b100);
    @(negedge clock) chk("ready_drain0", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
    @(negedge clock) chk("ready_drain1", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    do_load(6'd21, 32'h401, 32'd0, 3'b100, 0, 0, 0, 32'h0000_C300);

    // Flush in REQ without grant.
    hs(6'd22, 32'h500, 32'd0, 3'b010);
    bus.flush = 1'b1;
    @(negedge clock) chk("mem_req_flush", {31'd0, bus.mem_req}, 32'd1);
    step();
    bus.flush = 1'b0; exp_mem_ok = 1'b0;
    @(negedge clock) chk("req_flush_idle", {31'd0, bus.mem_req}, 32'd0);
    chk("req_flush_ready", {31'd0, bus.issue_ready}, 32'd1);
    step();

    // Flush in REQ with grant drains; a second flush in DRAIN changes nothing.
    hs(6'd23, 32'h504, 32'd0, 3'b010);
    bus.mem_gnt = 1'b1; bus.flush = 1'b1;
    @(negedge clock); step();
    bus.mem_gnt = 1'b0; exp_mem_ok = 1'b0;
    @(negedge clock) chk("ready_drain_flush", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.flush = 1'b0; bus.mem_rvalid = 1'b1;
    @(negedge clock) chk("ready_drain_rv", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    @(negedge clock) chk("ready_after_drain", {31'd0, bus.issue_ready}, 32'd1);
    step();

    // Flush in WAIT together with rvalid: data dropped, straight to IDLE.
    hs(6'd24, 32'h508, 32'd0, 3'b010);
    bus.mem_gnt = 1'b1;
    @(negedge clock); step();
    bus.mem_gnt = 1'b0; exp_mem_ok = 1'b0;
    bus.flush = 1'b1; bus.mem_rvalid = 1'b1;
    @(negedge clock); step();
    bus.flush = 1'b0; bus.mem_rvalid = 1'b0;
    @(negedge clock) chk("ready_flush_rv", {31'd0, bus.issue_ready}, 32'd1);
    step();

    // Flush in BCAST coinciding with cdb_gnt: not a broadcast.
    hs(6'd25, 32'h1, 32'd0, 3'b010);
    bus.flush = 1'b1; bus.cdb_gnt = 1'b1;
    @(negedge clock) chk("cdb_req_flush", {31'd0, bus.cdb_req}, 32'd1);
    step();
    bus.flush = 1'b0; bus.cdb_gnt = 1'b0; exp_cdb_ok = 1'b0;
    @(negedge clock) chk("ready_flush_bcast", {31'd0, bus.issue_ready}, 32'd1);
    step();

    // Flush in IDLE blocks a concurrent issue.
    issue(6'd26, 32'h600, 32'd0, 3'b010);
    bus.flush = 1'b1;
    @(negedge clock) chk("ready_flush_idle", {31'd0, bus.issue_ready}, 32'd0);
    step();
    bus.flush = 1'b0; bus.issue_valid = 1'b0;
    @(negedge clock) chk("no_req_after_block", {31'd0, bus.mem_req}, 32'd0);
    step();

    // Reset in the middle of BCAST drops cdb_req without a clock edge.
    hs(6'd27, 32'h700, 32'd4, 3'b010);
    bus.mem_gnt = 1'b1;
    @(negedge clock); step();
    bus.mem_gnt = 1'b0; exp_mem_ok = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    @(negedge clock); step();
    bus.mem_rvalid = 1'b0;
    exp_data = 32'h1234_5678; exp_exc = 1'b0; exp_cdb_ok = 1'b1;
    @(negedge clock) chk("cdb_before_rst", {31'd0, bus.cdb_req}, 32'd1);
    #2 reset = 1'b1;
    exp_cdb_ok = 1'b0;
    #1 chk("cdb_req_async_rst", {31'd0, bus.cdb_req}, 32'd0);
    chk("cdb_data_async_rst", bus.cdb_data, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clock) chk("ready_after_rst", {31'd0, bus.issue_ready}, 32'd1);
    step();
    do_load(6'd28, 32'h800, 32'd1, 3'b001, 0, 0, 0, 32'h0000_0000);
    do_load(6'd29, 32'h800, 32'd2, 3'b001, 0, 0, 0, 32'h7FFF_0000);

    // Reset in WAIT: no drain afterwards.
    hs(6'd30, 32'h900, 32'd0, 3'b010);
    bus.mem_gnt = 1'b1;
    @(negedge clock); step();
    bus.mem_gnt = 1'b0; exp_mem_ok = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock) chk("ready_rst_wait", {31'd0, bus.issue_ready}, 32'd1);
    step();
    do_load(6'd31, 32'hA00, 32'd3, 3'b100, 0, 0, 0, 32'hF100_0000);

    step();
    chk("broadcast_count", nbc, exp_bc);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/load_exec_unit.md
LOAD_EXEC_UNIT -- requirements
Module: load_exec_unit

Interface
REQ-001 The parameter list SHALL be: none; all widths fixed (ROB tag 6 bits, data 32 bits).
REQ-002 The ports SHALL be, in this order:
  clock  in  1  rising-edge clock
  reset  in  1  reset, asynchronous, active-high
  issue_valid  in  1  load RS presents a ready load
  issue_ready  out  1  unit can accept a load this cycle
  issue_rob  in  6  destination ROB tag
  issue_base  in  32  resolved base register value
  issue_offset  in  32  sign-extended immediate
  issue_subtype  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  flush  in  1  synchronous squash of the in-flight load
  mem_req  out  1  data-memory read request
  mem_addr  out  32  word-aligned address
  mem_gnt  in  1  memory accepted the request
  mem_rvalid  in  1  read data valid
  mem_rdata  in  32  full aligned word
  cdb_req  out  1  request CDB slot
  cdb_gnt  in  1  CDB slot granted this cycle
  cdb_rob  out  6  broadcast ROB tag
  cdb_data  out  32  extended load result
  cdb_exc  out  1  misaligned or illegal-subtype flag

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, BCAST, DRAIN, and hold exactly one load at a time.
REQ-004 issue_ready SHALL be 1 only in IDLE with flush=0; a handshake occurs when issue_valid & issue_ready at a rising edge.
REQ-005 On handshake the unit SHALL latch rob, subtype, and ea = issue_base + issue_offset (mod 2^32, carry discarded).
REQ-006 Alignment check at handshake: LH/LHU need ea[0]=0; LW needs ea[1:0]=00; LB/LBU always aligned; subtypes 011, 110, 111 are illegal.
REQ-007 Misaligned or illegal: next state BCAST with cdb_exc=1, cdb_data=0, no memory request.
REQ-008 Otherwise: next state REQ; mem_req=1 and mem_addr={ea[31:2],2'b00} are held stable until mem_gnt=1.
REQ-009 REQ with mem_gnt=1 SHALL go to WAIT; if mem_rvalid is also 1 in that same cycle, it SHALL be ignored (response not earlier than the cycle after grant).
REQ-010 WAIT with mem_rvalid=1 SHALL latch the extracted result and go to BCAST.
REQ-011 Extraction: byte lane = mem_rdata[8*ea[1:0]+7 : 8*ea[1:0]]; half lane = mem_rdata[16*ea[1]+15 : 16*ea[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-012 BCAST SHALL hold cdb_req=1 with stable cdb_rob/cdb_data/cdb_exc until cdb_gnt=1, then return to IDLE; issue_ready rises the following cycle.
REQ-013 cdb_rob/cdb_data/cdb_exc SHALL be 0 whenever cdb_req=0; mem_addr SHALL be 0 whenever mem_req=0.
REQ-014 Minimum latency, handshake edge to cdb_req high: 3 cycles (REQ 1, WAIT 1, BCAST); exception path 1 cycle.
REQ-015 flush=1 in REQ without mem_gnt, in BCAST (including with cdb_gnt), or in IDLE: go to IDLE, no broadcast; a concurrent issue handshake is blocked.
REQ-016 flush=1 in WAIT without mem_rvalid, or in REQ with mem_gnt=1: go to DRAIN.
REQ-017 flush=1 in WAIT with mem_rvalid=1: discard the data and go to IDLE.
REQ-018 DRAIN SHALL hold issue_ready=0, discard the next mem_rvalid, then go to IDLE; flush in DRAIN has no further effect.

Reset
REQ-019 reset=1 SHALL immediately force IDLE and clear all latches and outputs: issue_ready=1 once reset=0, all other outputs 0.
REQ-020 Reset during WAIT SHALL not drain; the memory side is reset concurrently by the same signal.

Verification
REQ-021 LB: base=0x100, off=3, rdata=0x80FF_0000 at rvalid -> mem_addr=0x100, cdb_data=0xFFFF_FF80.
REQ-022 LHU: base=0x200, off=-2 (0xFFFF_FFFE), rdata=0xBEEF_1234 -> mem_addr=0x1FC, cdb_data=0x0000_BEEF.
REQ-023 LW at ea=0x102 -> no mem_req, cdb_req one cycle after the handshake, cdb_exc=1, cdb_data=0.
REQ-024 LW at ea=0x40, mem_gnt delayed 3 cycles, cdb_gnt delayed 2 cycles -> mem_addr held stable throughout, single broadcast, issue_ready=0 until cdb_gnt.
REQ-025 flush in WAIT, rvalid two cycles later, then issue_valid held high -> no cdb_req, issue_ready returns the cycle after the drained rvalid.
REQ-026 reset asserted mid-BCAST -> cdb_req=0 without waiting for a clock edge; next load completes normally.
